uart_tx_frame: RTL and testbench

UART transmit framer that consumes the `en_tx` oversampling tick from the baud divisor. It serialises parallel bytes into asynchronous frames on `txd`: start bit, data LSB-first, optional parity, 1 or 2 stop bits. Each bit lasts exactly OVERSAMPLE `en_tx` pulses. A one-entry holding register lets the host queue the next byte while the current frame shifts, so consecutive frames go out with no idle gap.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_tx_frame.sv | 165 ++++++++++++++++
 tb/tb_uart_tx_frame.sv | 300 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings, parity modes and counter sizing.
// The receive side imports the same package.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE   = 3'd0;
  localparam state_t ST_START  = 3'd1;
  localparam state_t ST_DATA   = 3'd2;
  localparam state_t ST_PARITY = 3'd3;
  localparam state_t ST_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Width of a counter that must hold 0..n-1, never narrower than one bit.
  function automatic int tick_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_tx_frame.sv
// UART transmit framer: start bit, LSB-first data, optional parity, 1 or 2 stop bits,
// paced by the en_tx oversampling tick, with a one-entry holding register.
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY     = 0,
  parameter int STOP_BITS  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  output logic                 txd,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int TW = tick_width(OVERSAMPLE);
  localparam int BW = tick_width(DATA_BITS);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
  localparam logic          STOP_LAST = (STOP_BITS == 2);
  localparam logic          ODD_FLIP  = (PARITY == PAR_ODD);

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_q, tick_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic                 stop_q, stop_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] hold_q, hold_d;
  logic                 hold_full_q, hold_full_d;
  logic                 par_q, par_d;
  logic                 txd_q, txd_d;
  logic                 tx_ready_q;
  logic                 tx_done_q, tx_done_d;

  logic accept;
  logic bit_end;
  logic load;

  always_comb begin
    accept      = tx_valid && tx_ready_q;
    bit_end     = en_tx && (tick_q == TICK_LAST);
    load        = 1'b0;
    state_d     = state_q;
    tick_d      = tick_q;
    bit_d       = bit_q;
    stop_d      = stop_q;
    shift_d     = shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    par_d       = par_q;
    txd_d       = txd_q;
    tx_done_d   = 1'b0;

    if (accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end

    if (en_tx && (state_q != ST_IDLE)) begin
      tick_d = bit_end ? '0 : tick_q + TW'(1);
    end

    case (state_q)
      ST_IDLE: begin
        if (hold_full_q && en_tx) load = 1'b1;
      end
      ST_START: begin
        if (bit_end) begin
          state_d = ST_DATA;
          bit_d   = '0;
          txd_d   = shift_q[0];
          shift_d = shift_q >> 1;
        end
      end
      ST_DATA: begin
        if (bit_end) begin
          if (bit_q != BIT_LAST) begin
            bit_d   = bit_q + BW'(1);
            txd_d   = shift_q[0];
            shift_d = shift_q >> 1;
          end else if (PARITY != PAR_NONE) begin
            state_d = ST_PARITY;
            txd_d   = par_q;
          end else begin
            state_d = ST_STOP;
            stop_d  = 1'b0;
            txd_d   = 1'b1;
          end
        end
      end
      ST_PARITY: begin
        if (bit_end) begin
          state_d = ST_STOP;
          stop_d  = 1'b0;
          txd_d   = 1'b1;
        end
      end
      ST_STOP: begin
        if (bit_end) begin
          if (stop_q == STOP_LAST) begin
            tx_done_d = 1'b1;
            if (hold_full_q) load = 1'b1;
            else             state_d = ST_IDLE;
          end else begin
            stop_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        txd_d   = 1'b1;
      end
    endcase

    // A load (from IDLE or straight out of the last stop bit) starts the next frame.
    if (load) begin
      state_d     = ST_START;
      shift_d     = hold_q;
      par_d       = (^hold_q) ^ ODD_FLIP;
      hold_full_d = 1'b0;
      tick_d      = '0;
      txd_d       = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      tick_q      <= '0;
      bit_q       <= '0;
      stop_q      <= 1'b0;
      shift_q     <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      par_q       <= 1'b0;
      txd_q       <= 1'b1;
      tx_ready_q  <= 1'b1;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      tick_q      <= tick_d;
      bit_q       <= bit_d;
      stop_q      <= stop_d;
      shift_q     <= shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      par_q       <= par_d;
      txd_q       <= txd_d;
      tx_ready_q  <= ~hold_full_d;
      tx_done_q   <= tx_done_d;
    end
  end

  assign tx_ready = tx_ready_q;
  assign txd      = txd_q;
  assign busy     = (state_q != ST_IDLE);
  assign tx_done  = tx_done_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: four instances cover no-parity, even, odd and two-stop
// configurations; outputs are logged every falling edge and frames are checked by sample index.
module tb_uart_tx_frame;

  localparam int LOG_N = 16384;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst = 1'b1;
  logic [3:0]      en_v = '0;
  logic [3:0]      valid_v = '0;
  logic [3:0][7:0] data_v = '0;
  logic [3:0]      ready_v, txd_v, busy_v, done_v;

  int en_mode [4] = '{1, 1, 1, 2};
  int div_cnt = 0;
  int cyc = 0;
  int checks = 0;
  int errors = 0;

  logic [3:0] txd_log   [LOG_N];
  logic [3:0] busy_log  [LOG_N];
  logic [3:0] done_log  [LOG_N];
  logic [3:0] ready_log [LOG_N];

  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(1)) u_base (
    .clk(clk), .rst(rst), .en_tx(en_v[0]), .tx_data(data_v[0]), .tx_valid(valid_v[0]),
    .tx_ready(ready_v[0]), .txd(txd_v[0]), .busy(busy_v[0]), .tx_done(done_v[0]));
  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(1), .STOP_BITS(1)) u_even (
    .clk(clk), .rst(rst), .en_tx(en_v[1]), .tx_data(data_v[1]), .tx_valid(valid_v[1]),
    .tx_ready(ready_v[1]), .txd(txd_v[1]), .busy(busy_v[1]), .tx_done(done_v[1]));
  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(2), .STOP_BITS(1)) u_odd (
    .clk(clk), .rst(rst), .en_tx(en_v[2]), .tx_data(data_v[2]), .tx_valid(valid_v[2]),
    .tx_ready(ready_v[2]), .txd(txd_v[2]), .busy(busy_v[2]), .tx_done(done_v[2]));
  uart_tx_frame #(.DATA_BITS(8), .OVERSAMPLE(16), .PARITY(0), .STOP_BITS(2)) u_stop2 (
    .clk(clk), .rst(rst), .en_tx(en_v[3]), .tx_data(data_v[3]), .tx_valid(valid_v[3]),
    .tx_ready(ready_v[3]), .txd(txd_v[3]), .busy(busy_v[3]), .tx_done(done_v[3]));

  // Log outputs and generate en_tx: mode 0 = off, 1 = every 4th clk, 2 = constant 1.
  always @(negedge clk) begin
    if (cyc < LOG_N) begin
      txd_log[cyc]   = txd_v;
      busy_log[cyc]  = busy_v;
      done_log[cyc]  = done_v;
      ready_log[cyc] = ready_v;
    end
    cyc++;
    div_cnt = (div_cnt + 1) % 4;
    for (int i = 0; i < 4; i++)
      en_v[i] = (en_mode[i] == 2) || ((en_mode[i] == 1) && (div_cnt == 0));
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(3);
    checks++; if (txd_v !== 4'hF) begin errors++; $display("[TB] FAIL reset_txd got %b expected 1111", txd_v); end
    checks++; if (ready_v !== 4'hF) begin errors++; $display("[TB] FAIL reset_ready got %b expected 1111", ready_v); end
    checks++; if (busy_v !== 4'h0) begin errors++; $display("[TB] FAIL reset_busy got %b expected 0000", busy_v); end
    checks++; if (done_v !== 4'h0) begin errors++; $display("[TB] FAIL reset_done got %b expected 0000", done_v); end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_basic();
    int start, fl, busy_cnt, done_cnt;
    logic [9:0] frame;
    frame = {1'b1, 8'hA5, 1'b0};
    start = cyc;
    data_v[0] = 8'hA5; valid_v[0] = 1'b1;
    tick(1);
    valid_v[0] = 1'b0;
    tick(720);
    fl = -1;
    for (int j = start; j < cyc; j++) if (fl < 0 && txd_log[j][0] == 1'b0) fl = j;
    checks++; if (fl < 0) begin errors++; $display("[TB] FAIL basic_start got none expected start bit"); fl = start; end
    for (int k = 0; k < 10; k++) begin
      checks++;
      if (txd_log[fl + 64*k + 32][0] !== frame[k]) begin
        errors++; $display("[TB] FAIL basic_bit%0d got %b expected %b", k, txd_log[fl + 64*k + 32][0], frame[k]);
      end
    end
    checks++; if ({txd_log[fl+63][0], txd_log[fl+64][0]} !== 2'b01) begin
      errors++; $display("[TB] FAIL basic_start_len got %b%b expected 01", txd_log[fl+63][0], txd_log[fl+64][0]);
    end
    busy_cnt = 0; done_cnt = 0;
    for (int j = start; j < cyc; j++) begin
      if (busy_log[j][0] === 1'b1) busy_cnt++;
      if (done_log[j][0] === 1'b1) done_cnt++;
    end
    checks++; if (busy_cnt != 640) begin errors++; $display("[TB] FAIL basic_busy_len got %0d expected 640", busy_cnt); end
    checks++; if (done_cnt != 1) begin errors++; $display("[TB] FAIL basic_done_count got %0d expected 1", done_cnt); end
    checks++; if (done_log[fl+640][0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_done_pos got %b expected 1", done_log[fl+640][0]); end
    checks++; if (txd_log[fl+640][0] !== 1'b1) begin errors++; $display("[TB] FAIL basic_idle got %b expected 1", txd_log[fl+640][0]); end
  endtask

  task automatic test_parity();
    int start, fl;
    logic [10:0] frame [3];
    frame[1] = {1'b1, 1'b0, 8'hA5, 1'b0};
    frame[2] = {1'b1, 1'b1, 8'hA5, 1'b0};
    start = cyc;
    data_v[1] = 8'hA5; data_v[2] = 8'hA5; valid_v[1] = 1'b1; valid_v[2] = 1'b1;
    tick(1);
    valid_v[1] = 1'b0; valid_v[2] = 1'b0;
    tick(780);
    for (int i = 1; i < 3; i++) begin
      fl = -1;
      for (int j = start; j < cyc; j++) if (fl < 0 && txd_log[j][i] == 1'b0) fl = j;
      checks++; if (fl < 0) begin errors++; $display("[TB] FAIL parity_start_inst%0d got none expected start bit", i); fl = start; end
      for (int k = 0; k < 11; k++) begin
        checks++;
        if (txd_log[fl + 64*k + 32][i] !== frame[i][k]) begin
          errors++; $display("[TB] FAIL parity_inst%0d_bit%0d got %b expected %b", i, k, txd_log[fl + 64*k + 32][i], frame[i][k]);
        end
      end
      checks++; if (done_log[fl+704][i] !== 1'b1) begin errors++; $display("[TB] FAIL parity_inst%0d_done got %b expected 1", i, done_log[fl+704][i]); end
    end
    frame[1] = {1'b1, 1'b1, 8'h07, 1'b0};
    start = cyc;
    data_v[1] = 8'h07; valid_v[1] = 1'b1;
    tick(1);
    valid_v[1] = 1'b0;
    tick(780);
    fl = -1;
    for (int j = start; j < cyc; j++) if (fl < 0 && txd_log[j][1] == 1'b0) fl = j;
    checks++; if (fl < 0) begin errors++; $display("[TB] FAIL parity07_start got none expected start bit"); fl = start; end
    for (int k = 0; k < 11; k++) begin
      checks++;
      if (txd_log[fl + 64*k + 32][1] !== frame[1][k]) begin
        errors++; $display("[TB] FAIL parity07_bit%0d got %b expected %b", k, txd_log[fl + 64*k + 32][1], frame[1][k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int start, fl, waited, busy_cnt;
    logic [29:0] frames;
    frames = {1'b1, 8'h3C, 1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 8'h55, 1'b0};
    start = cyc;
    data_v[0] = 8'h55; valid_v[0] = 1'b1;
    tick(1);
    valid_v[0] = 1'b0;
    checks++; if (ready_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_drop got %b expected 0", ready_v[0]); end
    waited = 0;
    while (busy_v[0] !== 1'b1 && waited < 16) begin tick(1); waited++; end
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_load got %b expected 1", busy_v[0]); end
    checks++; if (ready_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL b2b_ready_rise got %b expected 1", ready_v[0]); end
    tick(100);
    data_v[0] = 8'hAA; valid_v[0] = 1'b1;
    tick(1);
    checks++; if (ready_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_ready_second got %b expected 0", ready_v[0]); end
    data_v[0] = 8'h3C;
    waited = 0;
    while (ready_v[0] !== 1'b1 && waited < 1000) begin tick(1); waited++; end
    tick(1);
    valid_v[0] = 1'b0;
    checks++; if (waited < 400 || waited >= 1000) begin errors++; $display("[TB] FAIL b2b_stall got %0d clks expected 400..999", waited); end
    tick(1300);
    fl = -1;
    for (int j = start; j < cyc; j++) if (fl < 0 && txd_log[j][0] == 1'b0) fl = j;
    checks++; if (fl < 0) begin errors++; $display("[TB] FAIL b2b_start got none expected start bit"); fl = start; end
    for (int k = 0; k < 30; k++) begin
      checks++;
      if (txd_log[fl + 64*k + 32][0] !== frames[k]) begin
        errors++; $display("[TB] FAIL b2b_bit%0d got %b expected %b", k, txd_log[fl + 64*k + 32][0], frames[k]);
      end
    end
    checks++; if ({txd_log[fl+639][0], txd_log[fl+640][0]} !== 2'b10) begin
      errors++; $display("[TB] FAIL b2b_no_gap got %b%b expected 10", txd_log[fl+639][0], txd_log[fl+640][0]);
    end
    checks++; if ({ready_log[fl+639][0], ready_log[fl+640][0], ready_log[fl+641][0]} !== 3'b010) begin
      errors++; $display("[TB] FAIL b2b_ready_seq got %b%b%b expected 010", ready_log[fl+639][0], ready_log[fl+640][0], ready_log[fl+641][0]);
    end
    checks++; if ({done_log[fl+640][0], done_log[fl+1280][0], done_log[fl+1920][0]} !== 3'b111) begin
      errors++; $display("[TB] FAIL b2b_done got %b%b%b expected 111", done_log[fl+640][0], done_log[fl+1280][0], done_log[fl+1920][0]);
    end
    busy_cnt = 0;
    for (int j = start; j < cyc; j++) if (busy_log[j][0] === 1'b1) busy_cnt++;
    checks++; if (busy_cnt != 1920) begin errors++; $display("[TB] FAIL b2b_busy_len got %0d expected 1920", busy_cnt); end
    checks++; if ({txd_log[fl+1920][0], busy_log[fl+1920][0]} !== 2'b10) begin
      errors++; $display("[TB] FAIL b2b_idle got txd %b busy %b expected 1 0", txd_log[fl+1920][0], busy_log[fl+1920][0]);
    end
  endtask

  task automatic test_stop2();
    int start, fl, low_cnt;
    start = cyc;
    data_v[3] = 8'h00; valid_v[3] = 1'b1;
    tick(1);
    valid_v[3] = 1'b0;
    tick(200);
    fl = -1;
    for (int j = start; j < cyc; j++) if (fl < 0 && txd_log[j][3] == 1'b0) fl = j;
    checks++; if (fl < 0) begin errors++; $display("[TB] FAIL stop2_start got none expected start bit"); fl = start; end
    low_cnt = 0;
    for (int j = start; j < cyc; j++) if (txd_log[j][3] === 1'b0) low_cnt++;
    checks++; if (low_cnt != 144) begin errors++; $display("[TB] FAIL stop2_low_len got %0d expected 144", low_cnt); end
    checks++; if ({txd_log[fl+143][3], txd_log[fl+144][3], txd_log[fl+175][3]} !== 3'b011) begin
      errors++; $display("[TB] FAIL stop2_edges got %b%b%b expected 011", txd_log[fl+143][3], txd_log[fl+144][3], txd_log[fl+175][3]);
    end
    checks++; if ({busy_log[fl+175][3], busy_log[fl+176][3], done_log[fl+176][3]} !== 3'b101) begin
      errors++; $display("[TB] FAIL stop2_end got %b%b%b expected 101", busy_log[fl+175][3], busy_log[fl+176][3], done_log[fl+176][3]);
    end
  endtask

  task automatic test_reset_mid();
    int waited, fl0, start, low_cnt, busy_cnt;
    data_v[0] = 8'hF0; valid_v[0] = 1'b1;
    tick(1);
    valid_v[0] = 1'b0;
    waited = 0;
    while (busy_v[0] !== 1'b1 && waited < 16) begin tick(1); waited++; end
    checks++; if (busy_v[0] !== 1'b1) begin errors++; $display("[TB] FAIL rstmid_load got %b expected 1", busy_v[0]); end
    fl0 = cyc - 1;
    data_v[0] = 8'h0F; valid_v[0] = 1'b1;
    tick(1);
    valid_v[0] = 1'b0;
    checks++; if (ready_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_hold_full got %b expected 0", ready_v[0]); end
    tick(fl0 + 199 - (cyc - 1));
    checks++; if (txd_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL rstmid_pre_low got %b expected 0", txd_v[0]); end
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    checks++; if ({txd_v[0], busy_v[0], ready_v[0]} !== 3'b101) begin
      errors++; $display("[TB] FAIL rstmid_after got txd %b busy %b ready %b expected 1 0 1", txd_v[0], busy_v[0], ready_v[0]);
    end
    start = cyc;
    tick(800);
    low_cnt = 0; busy_cnt = 0;
    for (int j = start; j < cyc; j++) begin
      if (txd_log[j][0] !== 1'b1) low_cnt++;
      if (busy_log[j][0] !== 1'b0) busy_cnt++;
    end
    checks++; if (low_cnt != 0) begin errors++; $display("[TB] FAIL rstmid_no_frame got %0d low clks expected 0", low_cnt); end
    checks++; if (busy_cnt != 0) begin errors++; $display("[TB] FAIL rstmid_no_busy got %0d busy clks expected 0", busy_cnt); end
  endtask

  task automatic test_en_hold();
    int start, low_cnt, busy_cnt, waited, done_cnt;
    en_mode[0] = 0;
    tick(2);
    data_v[0] = 8'h81; valid_v[0] = 1'b1;
    tick(1);
    valid_v[0] = 1'b0;
    start = cyc;
    tick(1000);
    low_cnt = 0; busy_cnt = 0;
    for (int j = start; j < cyc; j++) begin
      if (txd_log[j][0] !== 1'b1) low_cnt++;
      if (busy_log[j][0] !== 1'b0) busy_cnt++;
    end
    checks++; if (low_cnt != 0) begin errors++; $display("[TB] FAIL enhold_txd got %0d low clks expected 0", low_cnt); end
    checks++; if (busy_cnt != 0) begin errors++; $display("[TB] FAIL enhold_busy got %0d busy clks expected 0", busy_cnt); end
    checks++; if (ready_v[0] !== 1'b0) begin errors++; $display("[TB] FAIL enhold_ready got %b expected 0", ready_v[0]); end
    en_mode[0] = 2;
    tick(1);
    en_mode[0] = 0;
    tick(1);
    checks++; if ({busy_v[0], txd_v[0]} !== 2'b10) begin
      errors++; $display("[TB] FAIL enhold_first_pulse got busy %b txd %b expected 1 0", busy_v[0], txd_v[0]);
    end
    en_mode[0] = 1;
    start = cyc;
    waited = 0;
    while (busy_v[0] !== 1'b0 && waited < 2000) begin tick(1); waited++; end
    tick(2);
    done_cnt = 0;
    for (int j = start; j < cyc; j++) if (done_log[j][0] === 1'b1) done_cnt++;
    checks++; if (done_cnt != 1 || waited >= 2000) begin
      errors++; $display("[TB] FAIL enhold_complete got %0d done pulses after %0d clks expected 1", done_cnt, waited);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_back_to_back();
    test_stop2();
    test_reset_mid();
    test_en_hold();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
